// File: rtl/proc_result_accum_if.sv
// Result-bus interface for proc_result_accum: upstream beat handshake plus summary handshake.
interface proc_result_accum_if #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_mode;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [DATA_W-1:0] out_max;
  logic [CNT_W-1:0]  out_cnt;
  logic [3:0]        out_mode_mask;
  logic              out_sat;

  modport master (
    output in_valid, in_data, in_mode, flush, out_ready,
    input  in_ready, out_valid, out_sum, out_max, out_cnt, out_mode_mask, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_mode, flush, out_ready,
    output in_ready, out_valid, out_sum, out_max, out_cnt, out_mode_mask, out_sat
  );
endinterface

// File: rtl/proc_result_accum.sv
// Windowed summary (sum, unsigned max, count, mode mask) of ALU result beats.
// Define PROC_ACCUM_SAT_EN for a saturating sum with sticky out_sat; otherwise the sum wraps.
module proc_result_accum #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 40,
  parameter int WIN    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  proc_result_accum_if.slave bus
);
  localparam int CNT_W = $clog2(WIN + 1);
  localparam int PAD_W = ACC_W - DATA_W;

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_e;

  state_e            state_q, state_d;
  logic              live_q;

  logic [ACC_W-1:0]  acc_sum_q, acc_sum_d;
  logic [DATA_W-1:0] acc_max_q, acc_max_d;
  logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
  logic [3:0]        acc_mask_q, acc_mask_d;

  logic [ACC_W-1:0]  out_sum_q, out_sum_d;
  logic [DATA_W-1:0] out_max_q, out_max_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [3:0]        out_mask_q, out_mask_d;

  logic [ACC_W-1:0]  base_sum;
  logic [DATA_W-1:0] base_max;
  logic [CNT_W-1:0]  base_cnt;
  logic [3:0]        base_mask;
  logic [ACC_W-1:0]  beat_ext;
  logic              accept;
  logic              close;

`ifdef PROC_ACCUM_SAT_EN
  logic              acc_sat_q, acc_sat_d;
  logic              out_sat_q, out_sat_d;
  logic              base_sat;
  logic [ACC_W:0]    sum_wide;
`endif

  // live_q keeps in_ready low while reset is asserted and for the release cycle.
  assign bus.in_ready  = live_q & (state_q != EMIT);
  assign bus.out_valid = (state_q == EMIT);
  assign accept        = bus.in_valid & bus.in_ready;

  always_comb begin
    state_d    = state_q;
    close      = 1'b0;
    acc_sum_d  = acc_sum_q;
    acc_max_d  = acc_max_q;
    acc_cnt_d  = acc_cnt_q;
    acc_mask_d = acc_mask_q;
    out_sum_d  = out_sum_q;
    out_max_d  = out_max_q;
    out_cnt_d  = out_cnt_q;
    out_mask_d = out_mask_q;
    beat_ext   = {{PAD_W{1'b0}}, bus.in_data};

    // A beat accepted in IDLE starts a fresh window, so the old accumulator is ignored.
    if (state_q == IDLE) begin
      base_sum  = '0;
      base_max  = '0;
      base_cnt  = '0;
      base_mask = '0;
    end else begin
      base_sum  = acc_sum_q;
      base_max  = acc_max_q;
      base_cnt  = acc_cnt_q;
      base_mask = acc_mask_q;
    end

`ifdef PROC_ACCUM_SAT_EN
    acc_sat_d = acc_sat_q;
    out_sat_d = out_sat_q;
    base_sat  = (state_q == IDLE) ? 1'b0 : acc_sat_q;
    sum_wide  = '0;
`endif

    if (accept) begin
`ifdef PROC_ACCUM_SAT_EN
      sum_wide  = {1'b0, base_sum} + {1'b0, beat_ext};
      acc_sum_d = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
      acc_sat_d = base_sat | sum_wide[ACC_W];
`else
      acc_sum_d = base_sum + beat_ext;
`endif
      acc_max_d  = (bus.in_data > base_max) ? bus.in_data : base_max;
      acc_cnt_d  = base_cnt + CNT_W'(1);
      acc_mask_d = base_mask | (4'b0001 << bus.in_mode);
    end

    unique case (state_q)
      IDLE: begin
        if (accept) state_d = ACCUM;
      end
      ACCUM: begin
        // A flush with a beat in the same cycle closes the window including that beat.
        if ((accept && (acc_cnt_d == CNT_W'(WIN))) || bus.flush) begin
          state_d = EMIT;
          close   = 1'b1;
        end
      end
      EMIT: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (close) begin
      out_sum_d  = acc_sum_d;
      out_max_d  = acc_max_d;
      out_cnt_d  = acc_cnt_d;
      out_mask_d = acc_mask_d;
`ifdef PROC_ACCUM_SAT_EN
      out_sat_d  = acc_sat_d;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      live_q     <= 1'b0;
      acc_sum_q  <= '0;
      acc_max_q  <= '0;
      acc_cnt_q  <= '0;
      acc_mask_q <= '0;
      out_sum_q  <= '0;
      out_max_q  <= '0;
      out_cnt_q  <= '0;
      out_mask_q <= '0;
    end else begin
      state_q    <= state_d;
      live_q     <= 1'b1;
      acc_sum_q  <= acc_sum_d;
      acc_max_q  <= acc_max_d;
      acc_cnt_q  <= acc_cnt_d;
      acc_mask_q <= acc_mask_d;
      out_sum_q  <= out_sum_d;
      out_max_q  <= out_max_d;
      out_cnt_q  <= out_cnt_d;
      out_mask_q <= out_mask_d;
    end
  end

`ifdef PROC_ACCUM_SAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_sat_q <= 1'b0;
      out_sat_q <= 1'b0;
    end else begin
      acc_sat_q <= acc_sat_d;
      out_sat_q <= out_sat_d;
    end
  end

  assign bus.out_sat = out_sat_q;
`else
  assign bus.out_sat = 1'b0;
`endif

  assign bus.out_sum       = out_sum_q;
  assign bus.out_max       = out_max_q;
  assign bus.out_cnt       = out_cnt_q;
  assign bus.out_mode_mask = out_mask_q;

endmodule
